// File: rtl/ng_clk_mon_if.sv
// Signal bundle between the two-phase clock generator side and the monitor.
// The master drives the phase pins and the error clear; the monitor reports status.
interface ng_clk_mon_if #(
    parameter int CNT_W = 16
);
    logic             CLK1;
    logic             CLK2;
    logic             CLR_ERR;
    logic [1:0]       PHASE;
    logic             CYCLE_STB;
    logic [CNT_W-1:0] CYCLE_CNT;
    logic             LOCKED;
    logic             SEQ_ERR;
    logic             OVERLAP_ERR;
    logic             STALL;

    modport master (
        output CLK1, CLK2, CLR_ERR,
        input  PHASE, CYCLE_STB, CYCLE_CNT, LOCKED, SEQ_ERR, OVERLAP_ERR, STALL
    );

    modport slave (
        input  CLK1, CLK2, CLR_ERR,
        output PHASE, CYCLE_STB, CYCLE_CNT, LOCKED, SEQ_ERR, OVERLAP_ERR, STALL
    );
endinterface

// File: rtl/ng_clk_mon.sv
// Two-phase clock monitor: oversamples CLK1/CLK2 on CK_CLK, follows the
// P1-gap-P2-gap sequence and reports lock, sticky faults, stalls and cycle count.
module ng_clk_mon #(
    parameter int CNT_W       = 16,
    parameter int LOCK_CYCLES = 4,
    parameter int STALL_MAX   = 1024
) (
    input logic         CK_CLK,
    input logic         NPURST,
    ng_clk_mon_if.slave mon
);
    localparam int                IDLE_W    = $clog2(STALL_MAX + 1);
    localparam logic [3:0]        LOCK_V    = 4'(LOCK_CYCLES);
    localparam logic [IDLE_W-1:0] STALL_V   = IDLE_W'(STALL_MAX);
    localparam logic [IDLE_W-1:0] STALL_PRE = IDLE_W'(STALL_MAX - 1);

    typedef enum logic [2:0] {SYNC, P1, GAP1, P2, GAP2} state_t;

    // Bit 0 carries the CLK1 path, bit 1 the CLK2 path.
    logic [1:0]        meta_q, meta_d, smp_q, smp_d, prev_q, prev_d;
    logic [1:0]        phase_q, phase_d;
    state_t            state_q, state_d;
    logic [3:0]        lock_q, lock_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stb_q, stb_d, seq_q, seq_d, ovl_q, ovl_d;

    logic [1:0] rise, fall;
    logic       any_edge, seq_fault, ovl_fault, done, stall_hit, restart;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves one unassigned (no latches).
    always_comb begin
        meta_d  = {mon.CLK2, mon.CLK1};
        smp_d   = meta_q;
        prev_d  = smp_q;
        phase_d = smp_q;

        rise      = smp_q & ~prev_q;
        fall      = ~smp_q & prev_q;
        any_edge  = |(smp_q ^ prev_q);
        seq_fault = 1'b0;
        ovl_fault = &smp_q;
        done      = 1'b0;
        state_d   = state_q;

        unique case (state_q)
            SYNC: if (rise[0] && !smp_q[1]) state_d = P1;
            P1: begin
                if (rise[1]) begin
                    seq_fault = 1'b1;
                    ovl_fault = 1'b1;
                end else if (fall[0]) begin
                    state_d = GAP1;
                end
            end
            GAP1: begin
                if (rise[0])      seq_fault = 1'b1;
                else if (rise[1]) state_d   = P2;
            end
            P2: begin
                if (rise[0]) begin
                    seq_fault = 1'b1;
                    ovl_fault = 1'b1;
                end else if (fall[1]) begin
                    state_d = GAP2;
                    done    = 1'b1;
                end
            end
            GAP2: begin
                if (rise[1])      seq_fault = 1'b1;
                else if (rise[0]) state_d   = P1;
            end
            default: state_d = SYNC;
        endcase

        // Stall acts on the sample where the idle counter reaches STALL_MAX.
        stall_hit = !any_edge && (idle_q == STALL_PRE);
        if (any_edge)               idle_d = '0;
        else if (idle_q == STALL_V) idle_d = idle_q;
        else                        idle_d = idle_q + IDLE_W'(1);

        restart = seq_fault || stall_hit || mon.CLR_ERR;
        lock_d  = lock_q;
        if (restart) begin
            state_d = SYNC;
            lock_d  = '0;
        end else if (done && lock_q != LOCK_V) begin
            lock_d = lock_q + 4'd1;
        end

        // A fault in the same sample as CLR_ERR keeps its flag set.
        seq_d = seq_fault || (seq_q && !mon.CLR_ERR);
        ovl_d = ovl_fault || (ovl_q && !mon.CLR_ERR);
        stb_d = done;
        cnt_d = done ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge CK_CLK or negedge NPURST) begin
        if (!NPURST) begin
            meta_q  <= '0;
            smp_q   <= '0;
            prev_q  <= '0;
            phase_q <= '0;
            state_q <= SYNC;
            lock_q  <= '0;
            idle_q  <= '0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            seq_q   <= 1'b0;
            ovl_q   <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            smp_q   <= smp_d;
            prev_q  <= prev_d;
            phase_q <= phase_d;
            state_q <= state_d;
            lock_q  <= lock_d;
            idle_q  <= idle_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            seq_q   <= seq_d;
            ovl_q   <= ovl_d;
        end
    end

    assign mon.PHASE       = phase_q;
    assign mon.CYCLE_STB   = stb_q;
    assign mon.CYCLE_CNT   = cnt_q;
    assign mon.LOCKED      = (lock_q == LOCK_V);
    assign mon.SEQ_ERR     = seq_q;
    assign mon.OVERLAP_ERR = ovl_q;
    assign mon.STALL       = (idle_q == STALL_V);
endmodule

// File: tb/tb_ng_clk_mon.sv
// Directed bench for ng_clk_mon: stimulus queues expected cycle-complete results,
// a negedge monitor pops them on every CYCLE_STB; status flags are checked inline.
module tb_ng_clk_mon;
    localparam int CNT_W     = 4;
    localparam int LOCK_CYC  = 4;
    localparam int STALL_MAX = 40;

    logic ck   = 1'b0;
    logic nrst = 1'b0;

    ng_clk_mon_if #(.CNT_W(CNT_W)) bus ();

    ng_clk_mon #(
        .CNT_W      (CNT_W),
        .LOCK_CYCLES(LOCK_CYC),
        .STALL_MAX  (STALL_MAX)
    ) dut (
        .CK_CLK(ck),
        .NPURST(nrst),
        .mon   (bus)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             locked;
    } exp_t;

    exp_t             exp_q[$];
    int               n_cmp    = 0;
    int               n_err    = 0;
    int               stb_seen = 0;
    int               stb_base = 0;
    logic [CNT_W-1:0] cnt_m    = '0;
    logic             prev_stb = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic phase(input logic c1, input logic c2, input int n);
        bus.CLK1 = c1;
        bus.CLK2 = c2;
        tick(n);
    endtask

    // Gap, CLK2 pulse, gap; the CLK2 fall completes a cycle.
    task automatic cycle_tail(input logic lock_exp);
        exp_t e;
        phase(1'b0, 1'b0, 8);
        phase(1'b0, 1'b1, 8);
        cnt_m    = cnt_m + CNT_W'(1);
        e.cnt    = cnt_m;
        e.locked = lock_exp;
        exp_q.push_back(e);
        phase(1'b0, 1'b0, 8);
    endtask

    task automatic cycle(input logic lock_exp);
        phase(1'b1, 1'b0, 8);
        cycle_tail(lock_exp);
    endtask

    task automatic clr_pulse();
        bus.CLR_ERR = 1'b1;
        tick(1);
        bus.CLR_ERR = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_phase"},  32'(bus.PHASE),       0);
        check({tag, "_stb"},    32'(bus.CYCLE_STB),   0);
        check({tag, "_cnt"},    32'(bus.CYCLE_CNT),   0);
        check({tag, "_locked"}, 32'(bus.LOCKED),      0);
        check({tag, "_seq"},    32'(bus.SEQ_ERR),     0);
        check({tag, "_ovl"},    32'(bus.OVERLAP_ERR), 0);
        check({tag, "_stall"},  32'(bus.STALL),       0);
    endtask

    // Scoreboard monitor: one expected entry per strobe, strobe exactly one cycle wide.
    always @(negedge ck) begin
        exp_t e;
        if (bus.CYCLE_STB) begin
            stb_seen++;
            check("stb_width", 32'(prev_stb), 0);
            check("stb_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stb_cnt",    32'(bus.CYCLE_CNT), 32'(e.cnt));
                check("stb_locked", 32'(bus.LOCKED),    32'(e.locked));
            end
        end
        prev_stb = bus.CYCLE_STB;
    end

    initial begin
        bus.CLK1    = 1'b0;
        bus.CLK2    = 1'b0;
        bus.CLR_ERR = 1'b0;

        // Reset and a clean six-cycle stream.
        tick(3);
        check_zero("reset");
        nrst = 1'b1;
        tick(2);
        for (int i = 0; i < 6; i++) cycle(i >= LOCK_CYC - 1);
        check("clean_cnt",    32'(bus.CYCLE_CNT),   6);
        check("clean_stbs",   32'(stb_seen),        6);
        check("clean_locked", 32'(bus.LOCKED),      1);
        check("clean_seq",    32'(bus.SEQ_ERR),     0);
        check("clean_ovl",    32'(bus.OVERLAP_ERR), 0);
        check("clean_stall",  32'(bus.STALL),       0);

        // CLK1 twice with no CLK2 between.
        phase(1'b1, 1'b0, 8);
        phase(1'b0, 1'b0, 8);
        phase(1'b1, 1'b0, 4);
        check("seq_set",     32'(bus.SEQ_ERR), 1);
        check("seq_unlock",  32'(bus.LOCKED),  0);
        check("seq_ovl",     32'(bus.OVERLAP_ERR), 0);
        phase(1'b1, 1'b0, 4);
        phase(1'b0, 1'b0, 8);
        for (int i = 0; i < 4; i++) cycle(i == 3);
        check("seq_relock", 32'(bus.LOCKED),  1);
        check("seq_sticky", 32'(bus.SEQ_ERR), 1);
        clr_pulse();
        check("seq_clr",        32'(bus.SEQ_ERR),   0);
        check("seq_clr_unlock", 32'(bus.LOCKED),    0);
        check("seq_clr_cnt",    32'(bus.CYCLE_CNT), 10);

        // CLK2 rises while CLK1 is high.
        phase(1'b1, 1'b0, 8);
        phase(1'b1, 1'b1, 4);
        check("ovl_phase", 32'(bus.PHASE),       3);
        check("ovl_set",   32'(bus.OVERLAP_ERR), 1);
        check("ovl_seq",   32'(bus.SEQ_ERR),     1);
        phase(1'b0, 1'b1, 4);
        phase(1'b0, 1'b0, 8);
        // Clear in the same cycle as a fresh overlap: overlap flag must survive.
        phase(1'b1, 1'b1, 4);
        clr_pulse();
        check("ovl_clr_hold", 32'(bus.OVERLAP_ERR), 1);
        check("ovl_clr_seq",  32'(bus.SEQ_ERR),     0);
        phase(1'b1, 1'b1, 3);
        phase(1'b0, 1'b0, 8);
        clr_pulse();
        check("ovl_clr", 32'(bus.OVERLAP_ERR), 0);

        // Lock, then stall.
        for (int i = 0; i < 4; i++) cycle(i == 3);
        tick(STALL_MAX + 2 - 8);
        check("stall_pre",        32'(bus.STALL),  0);
        check("stall_pre_locked", 32'(bus.LOCKED), 1);
        tick(1);
        check("stall_set",    32'(bus.STALL),       1);
        check("stall_unlock", 32'(bus.LOCKED),      0);
        check("stall_seq",    32'(bus.SEQ_ERR),     0);
        check("stall_ovl",    32'(bus.OVERLAP_ERR), 0);
        tick(2);
        check("stall_hold", 32'(bus.STALL), 1);
        phase(1'b1, 1'b0, 2);
        check("stall_late", 32'(bus.STALL), 1);
        tick(1);
        check("stall_clr", 32'(bus.STALL), 0);
        phase(1'b1, 1'b0, 5);
        cycle_tail(1'b0);
        check("stall_resume_cnt", 32'(bus.CYCLE_CNT), 15);

        // Counter wrap with a 4-bit count.
        nrst = 1'b0;
        tick(2);
        nrst  = 1'b1;
        cnt_m = '0;
        stb_base = stb_seen;
        tick(2);
        for (int i = 0; i < 17; i++) cycle(i >= LOCK_CYC - 1);
        check("wrap_cnt",  32'(bus.CYCLE_CNT),     1);
        check("wrap_stbs", 32'(stb_seen - stb_base), 17);

        // Reset in the middle of a CLK2 pulse.
        phase(1'b1, 1'b0, 8);
        phase(1'b0, 1'b0, 8);
        phase(1'b0, 1'b1, 4);
        nrst = 1'b0;
        #1;
        check_zero("midrst");
        tick(2);
        nrst  = 1'b1;
        cnt_m = '0;
        phase(1'b0, 1'b1, 4);
        phase(1'b0, 1'b0, 8);
        check("midrst_seq", 32'(bus.SEQ_ERR),     0);
        check("midrst_ovl", 32'(bus.OVERLAP_ERR), 0);
        check("midrst_cnt", 32'(bus.CYCLE_CNT),   0);
        cycle(1'b0);
        check("midrst_resume", 32'(bus.CYCLE_CNT), 1);

        tick(4);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
